spawn_scheduler: RTL and testbench

SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

---
 rtl/spawn_pkg.sv | 18 +
 rtl/spawn_scheduler_if.sv | 24 ++
 rtl/lane_random.sv | 30 +++
 rtl/spawn_scheduler.sv | 157 +++++++++++++++
 tb/tb_spawn_scheduler.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/spawn_pkg.sv
// Shared state encoding and default sizing for the enemy-tank spawn scheduler.
// No timing or flow control of its own; it only supplies types and constants.
package spawn_pkg;
  localparam int NUM_REQ_DEF         = 4;
  localparam int LANE_BITS_DEF       = 2;
  localparam int NUM_LANES_DEF       = 4;
  localparam int MAX_RETRIES_DEF     = 7;
  localparam int COOLDOWN_CYCLES_DEF = 1000;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    CHECK,
    GRANT,
    FAIL,
    COOLDOWN
  } state_e;
endpackage

// File: rtl/spawn_scheduler_if.sv
// Requester-side bundle: level requests and lane occupancy in, one-cycle grant/fail pulses out.
// Requesters hold req until they see grant or fail; the scheduler never drops a held request.
interface spawn_scheduler_if import spawn_pkg::*; #(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int LANE_BITS = LANE_BITS_DEF,
  parameter int NUM_LANES = NUM_LANES_DEF
) ();
  logic [NUM_REQ-1:0]   req;
  logic [NUM_LANES-1:0] lane_busy;
  logic [NUM_REQ-1:0]   grant;
  logic [LANE_BITS-1:0] grant_lane;
  logic [NUM_REQ-1:0]   fail;
  logic                 busy;

  modport master (
    output req, lane_busy,
    input  grant, grant_lane, fail, busy
  );

  modport slave (
    input  req, lane_busy,
    output grant, grant_lane, fail, busy
  );
endinterface

// File: rtl/lane_random.sv
// Pseudo-random lane source: free-running wrapping counter, captured on sample.
// Captured lane is valid the cycle after sample; no backpressure.
module lane_random import spawn_pkg::*; #(
  parameter int LANE_BITS = LANE_BITS_DEF,
  parameter int NUM_LANES = NUM_LANES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample,
  output logic [LANE_BITS-1:0] lane
);
  logic [LANE_BITS-1:0] cnt_q, cnt_d;
  logic [LANE_BITS-1:0] lane_q;

  always_comb begin
    cnt_d = (cnt_q == LANE_BITS'(NUM_LANES - 1)) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      lane_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (sample) lane_q <= cnt_q;
    end
  end

  assign lane = lane_q;
endmodule

// File: rtl/spawn_scheduler.sv
// Round-robin spawn arbiter with random lane draw; grant 3 cycles after req when the first draw is free.
// Losing requesters are held off by level req; optional post-grant cooldown under SPAWN_COOLDOWN_EN.
module spawn_scheduler import spawn_pkg::*; #(
  parameter int NUM_REQ         = NUM_REQ_DEF,
  parameter int LANE_BITS       = LANE_BITS_DEF,
  parameter int NUM_LANES       = NUM_LANES_DEF,
  parameter int MAX_RETRIES     = MAX_RETRIES_DEF,
  parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  spawn_scheduler_if.slave bus
);
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  state_e               state_q;
  logic [NUM_REQ-1:0]   winner_q, grant_q, fail_q;
  logic [IDX_W-1:0]     win_idx_q, rr_ptr_q;
  logic [IDX_W-1:0]     pick_idx, next_ptr;
  logic [LANE_BITS-1:0] lane, grant_lane_q;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 busy_q, sample, win_dropped, lane_free;

`ifdef SPAWN_COOLDOWN_EN
  localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  logic [CD_W-1:0] cd_q;
`else
  localparam int unused_cooldown_cycles = COOLDOWN_CYCLES;
`endif

  // First set request at or above ptr, wrapping; lowest offset from ptr wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    int               k;
    pick = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (r[IDX_W'(k)]) pick = IDX_W'(k);
    end
    return pick;
  endfunction

  always_comb begin
    pick_idx    = rr_pick(bus.req, rr_ptr_q);
    next_ptr    = (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;
    win_dropped = ((bus.req & winner_q) == '0);
    lane_free   = !bus.lane_busy[lane];
    retry_d     = retry_q + 1'b1;
    sample      = (state_q == SAMPLE);
  end

  lane_random #(
    .LANE_BITS (LANE_BITS),
    .NUM_LANES (NUM_LANES)
  ) u_lane_random (
    .clk    (clk),
    .reset  (reset),
    .sample (sample),
    .lane   (lane)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      winner_q     <= '0;
      win_idx_q    <= '0;
      retry_q      <= '0;
      grant_q      <= '0;
      fail_q       <= '0;
      grant_lane_q <= '0;
      busy_q       <= 1'b0;
`ifdef SPAWN_COOLDOWN_EN
      cd_q         <= '0;
`endif
    end else begin
      grant_q <= '0;
      fail_q  <= '0;
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            winner_q  <= NUM_REQ'(1) << pick_idx;
            win_idx_q <= pick_idx;
            retry_q   <= '0;
            busy_q    <= 1'b1;
            state_q   <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (win_dropped) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (win_dropped) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (lane_free) begin
            grant_q      <= winner_q;
            grant_lane_q <= lane;
            state_q      <= GRANT;
          end else begin
            retry_q <= retry_d;
            if (retry_d == RETRY_W'(MAX_RETRIES)) begin
              fail_q  <= winner_q;
              state_q <= FAIL;
            end else begin
              state_q <= SAMPLE;
            end
          end
        end
        GRANT: begin
          rr_ptr_q <= next_ptr;
`ifdef SPAWN_COOLDOWN_EN
          cd_q     <= '0;
          state_q  <= COOLDOWN;
`else
          busy_q   <= 1'b0;
          state_q  <= IDLE;
`endif
        end
        FAIL: begin
          rr_ptr_q <= next_ptr;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        COOLDOWN: begin
`ifdef SPAWN_COOLDOWN_EN
          if (cd_q == CD_W'(COOLDOWN_CYCLES - 1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cd_q <= cd_q + 1'b1;
          end
`else
          busy_q  <= 1'b0;
          state_q <= IDLE;
`endif
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grant_lane = grant_lane_q;
  assign bus.fail       = fail_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler: reset, latency, round-robin order, retry fail, abort, mid-op reset.
// Builds with or without SPAWN_COOLDOWN_EN; only the inter-grant gap expectation changes.
module tb_spawn_scheduler;
  localparam int CD = 10;
`ifdef SPAWN_COOLDOWN_EN
  localparam int CD_EXTRA = CD;
`else
  localparam int CD_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  spawn_scheduler_if #(.NUM_REQ(4), .LANE_BITS(2), .NUM_LANES(4)) sif ();

  spawn_scheduler #(
    .NUM_REQ         (4),
    .LANE_BITS       (2),
    .NUM_LANES       (4),
    .MAX_RETRIES     (7),
    .COOLDOWN_CYCLES (CD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles until a grant or fail pulse is visible, capped at 60.
  task automatic wait_event(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sif.grant == '0 && sif.fail == '0 && n < 60);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sif.busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(sif.busy), 0);
  endtask

  logic [3:0] b_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int n;
    reset         = 1'b1;
    sif.req       = '0;
    sif.lane_busy = '0;
    repeat (3) tick();
    chk("rst_grant", 32'(sif.grant), 0);
    chk("rst_fail",  32'(sif.fail), 0);
    chk("rst_lane",  32'(sif.grant_lane), 0);
    chk("rst_busy",  32'(sif.busy), 0);

    // First grant from reset: counter reads 1 during SAMPLE.
    reset   = 1'b0;
    sif.req = 4'b0001;
    tick();
    chk("a_busy",    32'(sif.busy), 1);
    chk("a_nogrant", 32'(sif.grant), 0);
    tick();
    tick();
    chk("a_grant", 32'(sif.grant), 4'b0001);
    chk("a_lane",  32'(sif.grant_lane), 1);
    sif.req = '0;
    tick();
    chk("a_pulse",     32'(sif.grant), 0);
    chk("a_lane_hold", 32'(sif.grant_lane), 1);
    wait_idle();

    // All four requesting: strict rotation from index 0.
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    sif.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_event(n);
      chk("b_gap",   32'(n), (k == 0) ? 3 : 4 + CD_EXTRA);
      chk("b_grant", 32'(sif.grant), 32'(b_exp[k]));
    end
    sif.req = '0;
    wait_idle();

    // Every lane busy: 7 draw rounds then fail to requester 2.
    sif.lane_busy = 4'b1111;
    sif.req       = 4'b0100;
    wait_event(n);
    chk("c_latency", 32'(n), 15);
    chk("c_fail",    32'(sif.fail), 4'b0100);
    chk("c_nogrant", 32'(sif.grant), 0);
    sif.req       = '0;
    sif.lane_busy = '0;
    tick();
    chk("c_pulse", 32'(sif.fail), 0);
    chk("c_idle",  32'(sif.busy), 0);
    sif.req = 4'b1001;
    wait_event(n);
    chk("c_rr_from3", 32'(sif.grant), 4'b1000);
    chk("c_rr_lat",   32'(n), 3);
    sif.req = '0;
    wait_idle();

    // Request withdrawn in CHECK: silent abort, pointer stays at 0.
    sif.req = 4'b0001;
    tick();
    tick();
    chk("d_in_check", 32'(sif.busy), 1);
    sif.req = '0;
    tick();
    chk("d_nogrant", 32'(sif.grant), 0);
    chk("d_nofail",  32'(sif.fail), 0);
    chk("d_idle",    32'(sif.busy), 0);
    sif.req = 4'b0011;
    wait_event(n);
    chk("d_rr_kept", 32'(sif.grant), 4'b0001);
    sif.req = '0;
    wait_idle();

    // Reset while in CHECK clears outputs at once and leaves the FSM idle.
    sif.req = 4'b0010;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("e_grant", 32'(sif.grant), 0);
    chk("e_fail",  32'(sif.fail), 0);
    chk("e_busy",  32'(sif.busy), 0);
    chk("e_lane",  32'(sif.grant_lane), 0);
    sif.req = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("e_stay_idle", 32'(sif.busy), 0);
    chk("e_no_grant",  32'(sif.grant), 0);
    chk("e_no_fail",   32'(sif.fail), 0);
    sif.req = 4'b0010;
    wait_event(n);
    chk("e_regrant",     32'(sif.grant), 4'b0010);
    chk("e_regrant_lat", 32'(n), 3);
    sif.req = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
